adc_scan_controller: RTL and testbench

- Sequencer for the multiplexed serial ADC front end.
- Runs repeated conversion frames over NUM_CH multiplexer channels:
  - drives adc_cnv, adc_sck, adc_step and adc_reset;
  - shifts adc_sdo into parallel samples;
  - presents each sample, tagged with its channel, to the downstream capture FIFO.
- Sits in the AD_clk domain, between the ADC/mux pins and the FIFO feeding the host pipe-out.

---
 rtl/adc_scan_controller.sv | 195 +++++++++++++++++++
 tb/tb_adc_scan_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_controller.sv
// Conversion-frame sequencer for the multiplexed serial ADC: drives cnv/sck/mux pins and emits channel-tagged samples.
// Optional ADC_SCAN_TEST_PATTERN_EN adds a test_mode input that replaces sample data with {frame, channel}.
module adc_scan_controller #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned CH_W       = 4,
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned CNV_CYCLES = 20,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic                 AD_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clr_overrun,
    input  logic                 fifo_full,
    input  logic                 adc_sdo,
`ifdef ADC_SCAN_TEST_PATTERN_EN
    input  logic                 test_mode,
`endif
    output logic                 adc_cnv,
    output logic                 adc_sck,
    output logic                 adc_step,
    output logic                 adc_reset,
    output logic [DATA_BITS-1:0] sample_data,
    output logic [CH_W-1:0]      sample_ch,
    output logic                 sample_valid,
    output logic                 sample_last,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned ACQ_CYCLES = 2 * DATA_BITS;
    localparam int unsigned CNT_MAX_A  = (CNV_CYCLES > ACQ_CYCLES) ? CNV_CYCLES : ACQ_CYCLES;
    localparam int unsigned CNT_MAX    = (GAP_CYCLES > CNT_MAX_A) ? GAP_CYCLES : CNT_MAX_A;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNV_LAST = CNT_W'(CNV_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST = CNT_W'(ACQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, INIT, CNV, ACQ, STEP, GAP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   cnv_d, sck_d, step_d, mux_rst_d, valid_d, last_d, busy_d, overrun_d;
    logic [DATA_BITS-1:0]   data_d;
    logic [CH_W-1:0]        sch_d;
`ifdef ADC_SCAN_TEST_PATTERN_EN
    logic [7:0]             frame_q, frame_d;
`endif

    // State, datapath and registered pin outputs
    always_ff @(posedge AD_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ch_q         <= '0;
            shift_q      <= '0;
            adc_cnv      <= 1'b0;
            adc_sck      <= 1'b0;
            adc_step     <= 1'b0;
            adc_reset    <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            sample_last  <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef ADC_SCAN_TEST_PATTERN_EN
            frame_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            shift_q      <= shift_d;
            adc_cnv      <= cnv_d;
            adc_sck      <= sck_d;
            adc_step     <= step_d;
            adc_reset    <= mux_rst_d;
            sample_data  <= data_d;
            sample_ch    <= sch_d;
            sample_valid <= valid_d;
            sample_last  <= last_d;
            busy         <= busy_d;
            overrun      <= overrun_d;
`ifdef ADC_SCAN_TEST_PATTERN_EN
            frame_q      <= frame_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        shift_d   = shift_q;
        cnv_d     = 1'b0;
        sck_d     = 1'b0;
        step_d    = 1'b0;
        mux_rst_d = 1'b0;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        data_d    = sample_data;
        sch_d     = sample_ch;
        busy_d    = (state_q != IDLE);
        overrun_d = overrun & ~clr_overrun;
`ifdef ADC_SCAN_TEST_PATTERN_EN
        frame_d   = frame_q;
`endif
        // sdo is captured at the end of each cycle the sck pin is high
        if (adc_sck) begin
            shift_d = {shift_q[DATA_BITS-2:0], adc_sdo};
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                mux_rst_d = 1'b1;
                ch_d      = '0;
                cnt_d     = '0;
                state_d   = CNV;
            end
            CNV: begin
                cnv_d = 1'b1;
                if (cnt_q == CNV_LAST) begin
                    cnt_d   = '0;
                    state_d = ACQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACQ: begin
                sck_d = ~cnt_q[0];
                if (cnt_q == ACQ_LAST) begin
                    cnt_d   = '0;
                    state_d = STEP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STEP: begin
`ifdef ADC_SCAN_TEST_PATTERN_EN
                data_d = test_mode ? DATA_BITS'({frame_q, 8'(ch_q)}) : shift_q;
`else
                data_d = shift_q;
`endif
                sch_d = ch_q;
                if (fifo_full) begin
                    overrun_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    last_d  = (ch_q == CH_LAST);
                end
                if (ch_q == CH_LAST) begin
                    mux_rst_d = 1'b1;
                    ch_d      = '0;
`ifdef ADC_SCAN_TEST_PATTERN_EN
                    frame_d   = frame_q + 8'd1;
`endif
                end else begin
                    step_d = 1'b1;
                    ch_d   = ch_q + CH_W'(1);
                end
                cnt_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (GAP_CYCLES != 0) begin
                    state_d = GAP;
                end else begin
                    state_d = CNV;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? CNV : IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Scoreboard bench for adc_scan_controller: directed per-channel sdo patterns, pin timing and overrun checks.
module tb_adc_scan_controller;

    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned CH_W      = 4;
    localparam int unsigned DATA_BITS = 16;

    logic AD_clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic clr_overrun = 1'b0;
    logic fifo_full = 1'b0;
    logic adc_sdo = 1'b0;
    logic adc_cnv, adc_sck, adc_step, adc_reset;
    logic [DATA_BITS-1:0] sample_data;
    logic [CH_W-1:0]      sample_ch;
    logic sample_valid, sample_last, busy, overrun;
`ifdef ADC_SCAN_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    adc_scan_controller dut (
        .AD_clk       (AD_clk),
        .reset        (reset),
        .enable       (enable),
        .clr_overrun  (clr_overrun),
        .fifo_full    (fifo_full),
        .adc_sdo      (adc_sdo),
`ifdef ADC_SCAN_TEST_PATTERN_EN
        .test_mode    (test_mode),
`endif
        .adc_cnv      (adc_cnv),
        .adc_sck      (adc_sck),
        .adc_step     (adc_step),
        .adc_reset    (adc_reset),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_last  (sample_last),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 AD_clk = ~AD_clk;

    int cyc = 0;
    always @(posedge AD_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [DATA_BITS-1:0] data;
        logic                 last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   last_step = 0;
    int   init_cyc = 0;
    logic [DATA_BITS-1:0] pat = '0;
    logic invert_sdo = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ADC model: present the next pattern bit, MSB first, while the sck pin is high
    initial begin
        int bidx;
        bidx = DATA_BITS - 1;
        forever begin
            @(posedge AD_clk);
            #1;
            if (adc_cnv) bidx = DATA_BITS - 1;
            else if (adc_sck && bidx >= 0) begin
                adc_sdo = pat[bidx];
                bidx--;
            end
        end
    end

    // Monitor: every strobe must match the oldest expectation
    always @(negedge AD_clk) begin
        if (sample_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_sample: ch %0d data 0x%0h arrived with nothing expected", sample_ch, sample_data);
            end else begin
                mon_e = sb.pop_front();
                check("sample{ch,data,last}", 32'({sample_ch, sample_data, sample_last}),
                      32'({mon_e.ch, mon_e.data, mon_e.last}));
            end
        end
    end

    task automatic wait_init();
        int t;
        t = 0;
        while (t < 10 && adc_reset !== 1'b1) begin
            @(negedge AD_clk);
            t++;
        end
        check("init_pulse", 32'(adc_reset), 32'd1);
        init_cyc = cyc;
    endtask

    task automatic run_ch(input logic [CH_W-1:0] ch, input logic [DATA_BITS-1:0] data, input logic ff,
                          input logic clr_hold, input logic drop_en, input logic chk_period);
        int   n_cnv, n_sck, clash, t;
        logic prev_sck, seen_cnv;
        exp_t e;
        pat         = invert_sdo ? ~data : data;
        fifo_full   = ff;
        clr_overrun = clr_hold;
        if (!ff) begin
            e.ch   = ch;
            e.data = data;
            e.last = (ch == CH_W'(NUM_CH - 1));
            sb.push_back(e);
        end
        n_cnv = 0; n_sck = 0; clash = 0; t = 0; prev_sck = 1'b0; seen_cnv = 1'b0;
        while (t < 200) begin
            @(negedge AD_clk);
            t++;
            if (adc_cnv) begin
                n_cnv++;
                seen_cnv = 1'b1;
            end
            if (adc_sck && !prev_sck) n_sck++;
            prev_sck = adc_sck;
            if (int'(adc_cnv) + int'(adc_sck) + int'(adc_step) + int'(adc_reset) > 1) clash++;
            if (drop_en && n_sck == 8) enable = 1'b0;
            if (seen_cnv && (adc_step || adc_reset)) break;
        end
        if (t >= 200) begin
            checks++;
            $display("FAIL step_timeout: ch %0d no step/reset pulse within 200 cycles", ch);
        end else begin
            check("cnv_cycles", 32'(n_cnv), 32'd20);
            check("sck_pulses", 32'(n_sck), 32'd16);
            check("pin_overlap", 32'(clash), 32'd0);
            check("mux_pin{step,reset}", 32'({adc_step, adc_reset}),
                  (ch == CH_W'(NUM_CH - 1)) ? 32'd1 : 32'd2);
            if (chk_period) check("channel_period", 32'(cyc - last_step), 32'd56);
        end
        last_step   = cyc;
        fifo_full   = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("reset_pins", 32'({adc_cnv, adc_sck, adc_step, adc_reset, sample_valid, sample_last, busy, overrun}), 32'd0);
        check("reset_sample", 32'({sample_ch, sample_data}), 32'd0);
        @(negedge AD_clk);
        @(negedge AD_clk);
        reset = 1'b0;
        @(negedge AD_clk);

        // Frame 1: latency, patterns, drop on ch 3
        enable = 1'b1;
        wait_init();
        run_ch(4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_sample_latency", 32'(last_step - init_cyc), 32'd53);
        run_ch(4'd1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ch(4'd2, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        check("overrun_clear_before_drop", 32'(overrun), 32'd0);
        run_ch(4'd3, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1);
        check("overrun_after_drop", 32'(overrun), 32'd1);
        run_ch(4'd4, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1);
        check("overrun_sticky", 32'(overrun), 32'd1);
        run_ch(4'd5, 16'h7FFE, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ch(4'd6, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ch(4'd7, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Frame 2: clear coinciding with a drop, then a lone clear, then enable drop mid-ACQ
        run_ch(4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        check("overrun_set_wins", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        @(negedge AD_clk);
        clr_overrun = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);
        run_ch(4'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_ch(4'd2, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ch(4'd3, 16'hCCCC, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ch(4'd4, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);
        run_ch(4'd5, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge AD_clk);
        check("idle_after_disable", 32'({busy, adc_cnv}), 32'd0);
        repeat (60) @(negedge AD_clk);
        check("no_pending_after_disable", 32'(sb.size()), 32'd0);

        // Re-enable restarts at channel 0
        enable = 1'b1;
        wait_init();
        run_ch(4'd0, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset during conversion
        begin
            int t;
            t = 0;
            while (t < 30 && adc_cnv !== 1'b1) begin
                @(negedge AD_clk);
                t++;
            end
            check("cnv_before_reset", 32'(adc_cnv), 32'd1);
        end
        repeat (5) @(negedge AD_clk);
        reset = 1'b1;
        #1;
        check("async_reset_pins", 32'({adc_cnv, adc_sck, adc_step, adc_reset, sample_valid, sample_last, busy, overrun}), 32'd0);
        check("async_reset_sample", 32'({sample_ch, sample_data}), 32'd0);
        @(negedge AD_clk);
        @(negedge AD_clk);
        reset = 1'b0;
        wait_init();
        run_ch(4'd0, 16'hC3A5, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        repeat (10) @(negedge AD_clk);
        check("final_idle", 32'(busy), 32'd0);

`ifdef ADC_SCAN_TEST_PATTERN_EN
        // Test pattern: data is {frame, channel}; sdo carries the complement to expose a wrong source
        reset = 1'b1;
        @(negedge AD_clk);
        reset = 1'b0;
        test_mode  = 1'b1;
        invert_sdo = 1'b1;
        enable = 1'b1;
        wait_init();
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                run_ch(CH_W'(c), {8'(f), 8'(c)}, 1'b0, 1'b0, 1'b0, (f != 0 || c != 0));
            end
        end
        enable = 1'b0;
        repeat (10) @(negedge AD_clk);
        test_mode  = 1'b0;
        invert_sdo = 1'b0;
`endif

        repeat (60) @(negedge AD_clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
